// File: rtl/interp_l_ctrl.sv
// interp_l_ctrl: valid/ready sequencer for a runtime interpolate-by-L datapath
module interp_l_ctrl #(
    parameter int MAX_L = 8,
    parameter int FW    = $clog2(MAX_L + 1),
    parameter int PW    = $clog2(MAX_L)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          src_valid_in,
    output logic          src_ready_out,
    output logic          dst_valid_out,
    input  logic          dst_ready_in,
    input  logic [FW-1:0] factor_in,
    input  logic          mode_in,
    output logic          en_out,
    output logic          zero_out,
    output logic [PW-1:0] phase_out,
    output logic          last_out,
    output logic          busy_out
);

    typedef enum logic [1:0] {IDLE = 2'b00, EMIT = 2'b01} state_t;

    state_t        state_q;
    logic [PW-1:0] phase_q;
    logic [FW-1:0] l_q;
    logic          mode_q;
    logic [FW-1:0] l_clamp;
    logic          emit;

    // outputs are pure decode of state, captured regs and handshake inputs
    always_comb begin
        emit          = state_q == EMIT;
        l_clamp       = factor_in <= FW'(1) ? FW'(1) : factor_in > FW'(MAX_L) ? FW'(MAX_L) : factor_in;
        last_out      = emit && FW'(phase_q) == l_q - FW'(1);
        src_ready_out = !emit || (last_out && dst_ready_in);
        en_out        = arst_n && src_valid_in && src_ready_out;
        dst_valid_out = emit;
        busy_out      = emit;
        phase_out     = emit ? phase_q : '0;
        zero_out      = emit && !mode_q && phase_q != '0;
    end

    // acceptance restarts a sample; an accepted beat advances or finishes it
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            l_q     <= FW'(1);
            mode_q  <= 1'b0;
        end else if (en_out) begin
            state_q <= EMIT;
            phase_q <= '0;
            l_q     <= l_clamp;
            mode_q  <= mode_in;
        end else if (emit && dst_ready_in) begin
            if (last_out) state_q <= IDLE;
            else phase_q <= phase_q + PW'(1);
        end else if (!emit) begin
            state_q <= IDLE;
        end
    end

endmodule

// File: tb/tb_interp_l_ctrl.sv
// tb_interp_l_ctrl: directed-vector check of interp_l_ctrl with MAX_L=8
module tb_interp_l_ctrl;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       src_valid_in;
    logic       src_ready_out;
    logic       dst_valid_out;
    logic       dst_ready_in;
    logic [3:0] factor_in;
    logic       mode_in;
    logic       en_out;
    logic       zero_out;
    logic [2:0] phase_out;
    logic       last_out;
    logic       busy_out;
    logic [8:0] obs;
    int         total = 0;
    int         bad = 0;

    interp_l_ctrl #(.MAX_L(8)) dut (
        .clk(clk), .arst_n(arst_n),
        .src_valid_in(src_valid_in), .src_ready_out(src_ready_out),
        .dst_valid_out(dst_valid_out), .dst_ready_in(dst_ready_in),
        .factor_in(factor_in), .mode_in(mode_in),
        .en_out(en_out), .zero_out(zero_out), .phase_out(phase_out),
        .last_out(last_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    assign obs = {src_ready_out, dst_valid_out, en_out, zero_out, last_out, busy_out, phase_out};

    function automatic logic [8:0] e(logic sr, logic dv, logic en, logic z, logic l, logic b, int ph);
        return {sr, dv, en, z, l, b, 3'(ph)};
    endfunction

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got sr/dv/en/z/l/b/ph=%b expected %b", tag, got, exp);
        end
    endtask

    // check the settled outputs, then move to 1ns past the next rising edge
    task automatic step(input string tag, input logic [8:0] exp);
        #1 chk(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    int ph4[7] = '{0, 1, 1, 1, 2, 3, 3};
    bit r4[7]  = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        arst_n = 1'b0; src_valid_in = 1'b1; dst_ready_in = 1'b0; factor_in = 4'd0; mode_in = 1'b0;
        #12 chk("rst", obs, e(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 arst_n = 1'b1; src_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) step("idle", e(1, 0, 0, 0, 0, 0, 0));

        factor_in = 4'd4; mode_in = 1'b0; src_valid_in = 1'b1; dst_ready_in = 1'b1;
        step("t2_acc", e(1, 0, 1, 0, 0, 0, 0));
        src_valid_in = 1'b0;
        step("t2_b0", e(0, 1, 0, 0, 0, 1, 0));
        step("t2_b1", e(0, 1, 0, 1, 0, 1, 1));
        step("t2_b2", e(0, 1, 0, 1, 0, 1, 2));
        step("t2_b3", e(1, 1, 0, 1, 1, 1, 3));
        step("t2_idle", e(1, 0, 0, 0, 0, 0, 0));

        factor_in = 4'd3; mode_in = 1'b1; src_valid_in = 1'b1;
        step("t3_acc", e(1, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 15; i++) begin
            if (i == 14) src_valid_in = 1'b0;
            step("t3_beat", e(i % 3 == 2, 1, i % 3 == 2 && i < 14, 0, i % 3 == 2, 1, i % 3));
        end
        step("t3_idle", e(1, 0, 0, 0, 0, 0, 0));

        factor_in = 4'd4; mode_in = 1'b0; src_valid_in = 1'b1; dst_ready_in = 1'b1;
        step("t4_acc", e(1, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) begin
            dst_ready_in = r4[i];
            src_valid_in = i < 6;
            step("t4_stall", e(ph4[i] == 3 && r4[i], 1, 0, ph4[i] != 0, ph4[i] == 3, 1, ph4[i]));
        end
        dst_ready_in = 1'b1;
        step("t4_idle", e(1, 0, 0, 0, 0, 0, 0));

        factor_in = 4'd0; mode_in = 1'b0; src_valid_in = 1'b1;
        step("t5_acc0", e(1, 0, 1, 0, 0, 0, 0));
        src_valid_in = 1'b0;
        step("t5_l1", e(1, 1, 0, 0, 1, 1, 0));
        step("t5_idle0", e(1, 0, 0, 0, 0, 0, 0));
        factor_in = 4'd15; src_valid_in = 1'b1;
        step("t5_acc15", e(1, 0, 1, 0, 0, 0, 0));
        src_valid_in = 1'b0;
        for (int p = 0; p < 8; p++) step("t5_l8", e(p == 7, 1, 0, p != 0, p == 7, 1, p));
        step("t5_idle8", e(1, 0, 0, 0, 0, 0, 0));

        factor_in = 4'd4; mode_in = 1'b0; src_valid_in = 1'b1;
        step("t6_acc", e(1, 0, 1, 0, 0, 0, 0));
        src_valid_in = 1'b0;
        step("t6_b0", e(0, 1, 0, 0, 0, 1, 0));
        factor_in = 4'd2;
        step("t6_b1", e(0, 1, 0, 1, 0, 1, 1));
        step("t6_b2", e(0, 1, 0, 1, 0, 1, 2));
        arst_n = 1'b0; src_valid_in = 1'b1;
        #1 chk("t6_rst", obs, e(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 chk("t6_rst_hold", obs, e(1, 0, 0, 0, 0, 0, 0));
        #2 arst_n = 1'b1;
        step("t6_acc2", e(1, 0, 1, 0, 0, 0, 0));
        src_valid_in = 1'b0;
        step("t6_n0", e(0, 1, 0, 0, 0, 1, 0));
        step("t6_n1", e(1, 1, 0, 1, 1, 1, 1));
        step("t6_idle", e(1, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
